// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode 7-segment scanner: BCD decode, leading-zero blanking, per-digit DP.
// Optional blink gating is compiled in when SEG7_BLINK_EN is defined; outputs are registered, 1 cycle after tick.
module seg7_scan_driver #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bcd_in,
  input  logic [3:0]  dp_en,
  input  logic        lz_blank,
  input  logic        blink,
  output logic [3:0]  an_n,
  output logic [6:0]  seg_n,
  output logic        dp_n
);

  localparam int DIV_W = $clog2(REFRESH_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_idx;
  logic             r_started;
  logic [3:0]       r_an_n;
  logic [6:0]       r_seg_n;
  logic             r_dp_n;

  logic             w_tick;
  logic [1:0]       w_idx_nxt;
  logic [3:0]       w_digit;
  logic [6:0]       w_seg;
  logic             w_blank;
  logic             w_force_off;
  logic             w_d3_z;
  logic             w_d2_z;
  logic             w_d1_z;

  assign w_tick = (r_div == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div <= '0;
    end else if (w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  // The first tick after reset must land on digit 0, not advance past it.
  assign w_idx_nxt = r_started ? (r_idx + 2'd1) : 2'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx     <= 2'd0;
      r_started <= 1'b0;
    end else if (w_tick) begin
      r_idx     <= w_idx_nxt;
      r_started <= 1'b1;
    end
  end

  assign w_digit = bcd_in[{w_idx_nxt, 2'b00} +: 4];
  assign w_d3_z  = (bcd_in[15:12] == 4'd0);
  assign w_d2_z  = (bcd_in[11:8] == 4'd0);
  assign w_d1_z  = (bcd_in[7:4] == 4'd0);

  always_comb begin
    w_seg = 7'b0111111;
    case (w_digit)
      4'd0:    w_seg = 7'b1000000;
      4'd1:    w_seg = 7'b1111001;
      4'd2:    w_seg = 7'b0100100;
      4'd3:    w_seg = 7'b0110000;
      4'd4:    w_seg = 7'b0011001;
      4'd5:    w_seg = 7'b0010010;
      4'd6:    w_seg = 7'b0000010;
      4'd7:    w_seg = 7'b1111000;
      4'd8:    w_seg = 7'b0000000;
      4'd9:    w_seg = 7'b0010000;
      default: w_seg = 7'b0111111;
    endcase
  end

  always_comb begin
    w_blank = 1'b0;
    case (w_idx_nxt)
      2'd3:    w_blank = w_d3_z;
      2'd2:    w_blank = w_d3_z & w_d2_z;
      2'd1:    w_blank = w_d3_z & w_d2_z & w_d1_z;
      default: w_blank = 1'b0;
    endcase
    w_blank = w_blank & lz_blank;
  end

`ifdef SEG7_BLINK_EN
  localparam int FC_W = $clog2(BLINK_FRAMES + 1);

  logic [FC_W-1:0] r_frame_cnt;
  logic [FC_W-1:0] w_frame_cnt_nxt;
  logic            r_phase_on;
  logic            w_phase_on_nxt;

  // Phase is evaluated with the same tick that selects digit 0 so whole frames go dark together.
  always_comb begin
    w_frame_cnt_nxt = r_frame_cnt;
    w_phase_on_nxt  = r_phase_on;
    if (!blink) begin
      w_frame_cnt_nxt = '0;
      w_phase_on_nxt  = 1'b1;
    end else if (w_tick && r_started && (r_idx == 2'd3)) begin
      if (r_frame_cnt == FC_W'(BLINK_FRAMES - 1)) begin
        w_frame_cnt_nxt = '0;
        w_phase_on_nxt  = ~r_phase_on;
      end else begin
        w_frame_cnt_nxt = r_frame_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_cnt <= '0;
      r_phase_on  <= 1'b1;
    end else begin
      r_frame_cnt <= w_frame_cnt_nxt;
      r_phase_on  <= w_phase_on_nxt;
    end
  end

  assign w_force_off = blink & ~w_phase_on_nxt;
`else
  logic w_unused_blink;
  assign w_unused_blink = blink;
  assign w_force_off    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_an_n  <= 4'b1111;
      r_seg_n <= 7'b1111111;
      r_dp_n  <= 1'b1;
    end else if (w_tick) begin
      if (w_blank || w_force_off) begin
        r_an_n  <= 4'b1111;
        r_seg_n <= 7'b1111111;
        r_dp_n  <= 1'b1;
      end else begin
        r_an_n  <= ~(4'b0001 << w_idx_nxt);
        r_seg_n <= w_seg;
        r_dp_n  <= ~dp_en[w_idx_nxt];
      end
    end
  end

  assign an_n  = r_an_n;
  assign seg_n = r_seg_n;
  assign dp_n  = r_dp_n;

endmodule
